// File: rtl/dmem_lsu.sv
// Data memory with byte/half/word load-store formatting, alignment and range checks.
// Loads are combinational (zero latency); stores commit on the rising clock edge.
// No handshake: invalid or in-sweep stores are dropped and counted in err_cnt.
module dmem_lsu #(
  parameter int DEPTH_LOG2 = 5,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       size,
  input  logic             ld_unsigned,
  input  logic [31:0]      addr,
  input  logic [31:0]      datain,
  output logic [31:0]      dataout,
  output logic             misalign,
  output logic             oob,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Clear sequencer states
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_LAST = {DEPTH_LOG2{1'b1}};
  localparam logic [ERR_W-1:0]      ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]      ERR_MAX  = {ERR_W{1'b1}};

  logic [31:0]           mem [DEPTH];
  logic [0:0]            state;
  logic [DEPTH_LOG2-1:0] ptr;

  logic [DEPTH_LOG2-1:0] widx;
  logic                  invalid;
  logic                  store_ok;
  logic                  store_bad;
  logic                  clr_wr;
  logic [3:0]            be;
  logic [31:0]           wdat;
  logic [31:0]           rd_word;
  logic [7:0]            rd_byte;
  logic [15:0]           rd_half;
  logic [31:0]           fmt;

  assign widx      = addr[DEPTH_LOG2+1:2];
  assign oob       = |addr[31:DEPTH_LOG2+2];
  assign busy      = (state == CLEAR);
  assign invalid   = misalign | oob | busy;
  assign store_ok  = we & ~invalid;
  assign store_bad = we & invalid;
  // The sweep only advances once reset has been released.
  assign clr_wr    = busy & ~rst;
  assign rd_word   = mem[widx];

  // Alignment check: halves need addr[0]=0, words (and reserved size) need addr[1:0]=0
  always_comb begin
    misalign = 1'b0;
    case (size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = addr[0];
      default: misalign = |addr[1:0];
    endcase
  end

  // Byte-enable and lane-replicated write data for the addressed size
  always_comb begin
    be   = 4'b1111;
    wdat = datain;
    case (size)
      2'b00: begin
        be   = 4'b0001 << addr[1:0];
        wdat = {4{datain[7:0]}};
      end
      2'b01: begin
        be   = addr[1] ? 4'b1100 : 4'b0011;
        wdat = {2{datain[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wdat = datain;
      end
    endcase
  end

  // Load lane selection and sign/zero extension; invalid accesses read as zero
  always_comb begin
    rd_byte = rd_word[7:0];
    case (addr[1:0])
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
    rd_half = addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (size)
      2'b00:   fmt = {{24{~ld_unsigned & rd_byte[7]}}, rd_byte};
      2'b01:   fmt = {{16{~ld_unsigned & rd_half[15]}}, rd_half};
      default: fmt = rd_word;
    endcase
    dataout = invalid ? 32'd0 : fmt;
  end

  // Memory array: sweep clears one word per edge, otherwise byte-masked CPU stores
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[ptr] <= 32'd0;
    end else if (store_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[widx][8*k +: 8] <= wdat[8*k +: 8];
      end
    end
  end

  // Clear sequencer: sweep every word from pointer 0 after each reset, then idle in READY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (state == CLEAR) begin
      ptr <= ptr + PTR_ONE;
      if (ptr == PTR_LAST) state <= READY;
    end
  end

  // Saturating count of stores that were dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (store_bad && (err_cnt != ERR_MAX)) begin
      err_cnt <= err_cnt + ERR_ONE;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with DEPTH_LOG2=5, ERR_W=8.
// Inputs change 1ns after a rising edge; outputs are sampled before the next edge.
// Each check goes through one task that counts comparisons and failures.
module tb_dmem_lsu;

  logic        clk;
  logic        rst;
  logic        we;
  logic [1:0]  size;
  logic        ld_unsigned;
  logic [31:0] addr;
  logic [31:0] datain;
  logic [31:0] dataout;
  logic        misalign;
  logic        oob;
  logic        busy;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  dmem_lsu #(.DEPTH_LOG2(5), .ERR_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .we(we),
    .size(size),
    .ld_unsigned(ld_unsigned),
    .addr(addr),
    .datain(datain),
    .dataout(dataout),
    .misalign(misalign),
    .oob(oob),
    .busy(busy),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One store, committed on the next rising edge
  task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    size   = sz;
    addr   = a;
    datain = d;
    we     = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // Combinational load check
  task automatic ld(input string tag, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] exp);
    we          = 1'b0;
    size        = sz;
    ld_unsigned = uns;
    addr        = a;
    #1;
    check(tag, dataout, exp);
  endtask

  // Wait for busy to fall, returning the number of edges taken (bounded)
  task automatic wait_sweep(output int n);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int bad;
    rst         = 1'b1;
    we          = 1'b0;
    size        = 2'b10;
    ld_unsigned = 1'b0;
    addr        = 32'd0;
    datain      = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_err", {24'd0, err_cnt}, 32'd0);
    check("rst_dataout", dataout, 32'd0);

    // Sweep interrupted by a reset pulse at cycle 10
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midsweep_busy", {31'd0, busy}, 32'd1);
    wait_sweep(n);
    check("sweep_len", n, 32);
    bad = 0;
    for (int w = 0; w < 32; w++) begin
      size = 2'b10;
      addr = 32'(w * 4);
      #1;
      if (dataout !== 32'd0) bad++;
    end
    check("clear_words_nonzero", bad, 0);
    check("post_sweep_err", {24'd0, err_cnt}, 32'd0);

    // Byte stores (upper datain bits must be ignored)
    store(2'b00, 32'h50, 32'h123456A3);
    store(2'b00, 32'h51, 32'hFFFFFF27);
    store(2'b00, 32'h52, 32'h00000079);
    store(2'b00, 32'h53, 32'hABCDEF15);
    ld("lw_50", 2'b10, 1'b0, 32'h50, 32'h157927A3);
    ld("lb_50", 2'b00, 1'b0, 32'h50, 32'hFFFFFFA3);
    ld("lbu_50", 2'b00, 1'b1, 32'h50, 32'h000000A3);
    ld("lb_51", 2'b00, 1'b0, 32'h51, 32'h00000027);
    ld("lb_53", 2'b00, 1'b0, 32'h53, 32'h00000015);

    // Halfword stores
    store(2'b10, 32'h60, 32'h00000258);
    store(2'b01, 32'h62, 32'hABCD8001);
    ld("lw_60", 2'b10, 1'b0, 32'h60, 32'h80010258);
    ld("lh_62", 2'b01, 1'b0, 32'h62, 32'hFFFF8001);
    ld("lhu_62", 2'b01, 1'b1, 32'h62, 32'h00008001);
    ld("lh_60", 2'b01, 1'b0, 32'h60, 32'h00000258);

    // Misaligned word store is suppressed
    store(2'b10, 32'h5C, 32'hCAFEF00D);
    size   = 2'b10;
    addr   = 32'h5D;
    datain = 32'h12345678;
    we     = 1'b1;
    #1;
    check("mis_sw_flag", {31'd0, misalign}, 32'd1);
    check("mis_sw_dataout", dataout, 32'd0);
    @(posedge clk);
    #1;
    we = 1'b0;
    check("mis_err_1", {24'd0, err_cnt}, 32'd1);
    ld("mis_word_kept", 2'b10, 1'b0, 32'h5C, 32'hCAFEF00D);
    size = 2'b01;
    addr = 32'h55;
    #1;
    check("mis_sh_55", {31'd0, misalign}, 32'd1);
    size = 2'b00;
    #1;
    check("mis_sb_55", {31'd0, misalign}, 32'd0);
    store(2'b00, 32'h55, 32'h0000005A);
    ld("sb_55_word", 2'b10, 1'b0, 32'h54, 32'h00005A00);
    check("sb_55_err", {24'd0, err_cnt}, 32'd1);
    size = 2'b11;
    addr = 32'h62;
    #1;
    check("mis_rsvd_62", {31'd0, misalign}, 32'd1);

    // Out of range
    addr = 32'h7C;
    #1;
    check("oob_7c", {31'd0, oob}, 32'd0);
    size   = 2'b10;
    addr   = 32'h80;
    datain = 32'hDEADBEEF;
    we     = 1'b1;
    #1;
    check("oob_80", {31'd0, oob}, 32'd1);
    @(posedge clk);
    #1;
    we = 1'b0;
    check("oob_err_2", {24'd0, err_cnt}, 32'd2);
    ld("oob_word0_kept", 2'b10, 1'b0, 32'h00, 32'h00000000);

    // Same-cycle store and load return old data until the edge
    size   = 2'b10;
    addr   = 32'h70;
    datain = 32'h11111111;
    we     = 1'b1;
    #1;
    check("same_cycle_old", dataout, 32'h00000000);
    @(posedge clk);
    #1;
    we = 1'b0;
    check("same_cycle_new", dataout, 32'h11111111);

    // Counter saturation
    size   = 2'b10;
    addr   = 32'h81;
    we     = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    we = 1'b0;
    check("err_saturate", {24'd0, err_cnt}, 32'h000000FF);

    // Store during the sweep is dropped and counted
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("re_rst_err", {24'd0, err_cnt}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    check("busy_before_store", {31'd0, busy}, 32'd1);
    store(2'b10, 32'h00, 32'h55AA55AA);
    check("busy_store_err", {24'd0, err_cnt}, 32'd1);
    wait_sweep(n);
    check("sweep2_len_rest", n, 26);
    ld("busy_store_dropped", 2'b10, 1'b0, 32'h00, 32'h00000000);
    ld("sweep2_cleared_70", 2'b10, 1'b0, 32'h70, 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised data memory with built-in load/store formatting for the single-cycle CPU. It replaces the fixed 32-word, word-only data RAM with these features:
- a configurable depth;
- byte, halfword and word stores and loads, with sign or zero extension;
- misalignment and out-of-range checking;
- a post-reset clear sequencer;
- a sticky error counter.

It sits between the ALU address output and the register-file write-back mux.

## Interface
- `DEPTH_LOG2`, default 5: the memory holds 2^DEPTH_LOG2 words of 32 bits.
- `ERR_W`, default 8: width of the suppressed-write counter.
- `clk`, input, 1 bit: clock; all writes are on the rising edge.
- `rst`, input, 1 bit: reset, asynchronous, active-high.
- `we`, input, 1 bit: store request.
- `size`, input, 2 bits: access size, 00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as word).
- `ld_unsigned`, input, 1 bit: 1 = zero-extend byte/half loads, 0 = sign-extend.
- `addr`, input, 32 bits: byte address.
- `datain`, input, 32 bits: store data, right-justified.
- `dataout`, output, 32 bits: formatted load data (combinational).
- `misalign`, output, 1 bit: the current access is misaligned (combinational).
- `oob`, output, 1 bit: the current address is outside the memory (combinational).
- `busy`, output, 1 bit: clear sweep in progress (registered).
- `err_cnt`, output, ERR_W bits: saturating count of suppressed stores (registered).

## Operation
- **Word index:** `widx = addr[DEPTH_LOG2+1:2]`. Byte lanes are little-endian: lane k is bits [8k+7:8k].
- **oob:** asserted when any bit of `addr[31:DEPTH_LOG2+2]` is 1.
- **misalign:** asserted when either condition holds:
  - `size` = 01 and `addr[0]` = 1;
  - `size` is 10 or 11 and `addr[1:0]` != 0.
- **Invalid access:** `misalign | oob | busy`.
- **Load formatting:**
  - Byte: lane `addr[1:0]` of word `widx`, extended to 32 bits.
  - Halfword: lanes {`addr[1]`\*2+1, `addr[1]`\*2}, extended.
  - Word: the whole word.
  - Extension follows `ld_unsigned`.
  - `dataout` = 0 whenever the access is invalid.
- **Store:**
  - On the rising edge with `we`=1 and a valid access:
    - byte writes `datain[7:0]` to lane `addr[1:0]`;
    - halfword writes `datain[15:0]` to the addressed half;
    - word writes all 32 bits.
  - Unaddressed lanes keep their contents.
- **Suppressed store:** `we`=1 with an invalid access. No memory lane changes, and `err_cnt` increments by 1, saturating at all-ones.
- **Clear sequencer FSM** (states `CLEAR` and `READY`):
  - `rst` asserted: asynchronously sets state = `CLEAR`, sweep pointer = 0, `err_cnt` = 0.
  - In `CLEAR`, each rising edge with `rst` low writes 0 to word[pointer] and increments the pointer.
  - When the pointer equals 2^DEPTH_LOG2−1, that word is cleared and the state goes to `READY`.
  - `READY` persists until the next `rst`.
- **busy:** `busy` = 1 exactly while the state is `CLEAR`.
- **Stores during the sweep:** CPU stores while `busy` are suppressed and counted.

## Timing
- **Reset values:** `busy` = 1 and `err_cnt` = 0 while `rst` is high and after it falls.
- **Combinational outputs under reset:** `dataout`, `misalign` and `oob` are combinational. `dataout` = 0 during `rst` and `busy` because the access is invalid.
- **Clear duration:** the sweep takes exactly 2^DEPTH_LOG2 rising edges after `rst` deasserts. `busy` falls after the last of these edges.
- **Reset mid-sweep:** restarts from pointer 0 and the full sweep is repeated.
- **Load latency:** zero. `dataout` reflects memory contents after the most recent edge.
- **Same-cycle store and load:** a store and a load to the same word in one cycle return the old data until the edge.
- **Store latency:** the store is visible on the cycle after the edge.
- **Counter:** `err_cnt` updates on the same edge as the suppressed store. At saturation it holds its value.

## Test plan
- **Reset sweep:** pulse `rst` mid-sweep at cycle 10.
  - `busy` stays high until 32 edges after the final deassertion.
  - Every word then reads 0 and `err_cnt` = 0.
- **Byte stores:**
  - Stores `sb` 0xA3 @0x50, `sb` 0x27 @0x51, `sb` 0x79 @0x52, `sb` 0x15 @0x53.
  - Word load @0x50 -> 0x157927A3.
  - `lb` @0x50 -> 0xFFFFFFA3; `lbu` @0x50 -> 0x000000A3.
- **Halfword stores:** `sw` 0x00000258 @0x60, then `sh` 0x8001 @0x62.
  - Word load @0x60 -> 0x80010258.
  - `lh` @0x62 -> 0xFFFF8001; `lhu` @0x62 -> 0x00008001.
- **Misalignment:** `sw` 0x12345678 @0x5D.
  - Response: `misalign`=1, `dataout`=0, `err_cnt` 0->1, word @0x5C unchanged.
  - `sh` @0x55 is also flagged; `sb` @0x55 is accepted.
- **Out of range:** `sw` @0x80 with DEPTH_LOG2=5.
  - Response: `oob`=1, no write, word @0x00 unchanged, `err_cnt` increments.
- **Counter saturation and busy suppression:**
  - 300 suppressed stores with ERR_W=8 -> `err_cnt` holds 0xFF.
  - A store issued during `busy` is dropped and counted.
